// File: rtl/afifo_wr_arb_if.sv
// Requester/afifo write-side bundle for afifo_wr_arb. With ASI_AFIFO_ARB_TAG_EN
// defined, afifo_d grows by IDW bits to carry the owning requester index.
interface afifo_wr_arb_if #(
  parameter int NREQ = 4,
  parameter int DW   = 128,
  parameter int IDW  = $clog2(NREQ)
);
`ifdef ASI_AFIFO_ARB_TAG_EN
  localparam int FDW = DW + IDW;
`else
  localparam int FDW = DW;
`endif

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_last;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               afifo_we;
  logic [FDW-1:0]     afifo_d;
  logic               afifo_wfull;
  logic [IDW-1:0]     grant_id;
  logic               busy;

  // arbiter side
  modport slave (
    input  req_valid, req_last, req_data, afifo_wfull,
    output req_ready, afifo_we, afifo_d, grant_id, busy
  );

  // requesters + afifo side
  modport master (
    output req_valid, req_last, req_data, afifo_wfull,
    input  req_ready, afifo_we, afifo_d, grant_id, busy
  );
endinterface

// File: rtl/afifo_wr_arb.sv
// Burst-granular round-robin arbiter driving the afifo write port.
// Optional source tag on afifo_d: define ASI_AFIFO_ARB_TAG_EN.
module afifo_wr_arb #(
  parameter int NREQ = 4,
  parameter int DW   = 128,
  parameter int MAXB = 16,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic            wclk,
  input  logic            wreset_n,
  afifo_wr_arb_if.slave   bus
);
  localparam int BCW = $clog2(MAXB + 1);

  typedef enum logic {IDLE, BURST} state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] grant_q, grant_d;
  logic [IDW-1:0] last_q, last_d;
  logic [BCW-1:0] cnt_q, cnt_d;

  logic [DW-1:0]  data_a [NREQ];
  logic [IDW-1:0] winner;
  logic           found;
  int             idx;
  logic           busy, hs;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_lane
      assign data_a[gi]        = bus.req_data[gi*DW +: DW];
      assign bus.req_ready[gi] = busy && (grant_q == IDW'(gi)) && !bus.afifo_wfull;
    end
  endgenerate

  assign busy = (state_q == BURST);
  assign hs   = busy && bus.req_valid[grant_q] && !bus.afifo_wfull;

  assign bus.afifo_we = hs;
  assign bus.grant_id = grant_q;
  assign bus.busy     = busy;
`ifdef ASI_AFIFO_ARB_TAG_EN
  assign bus.afifo_d  = {grant_q, data_a[grant_q]};
`else
  assign bus.afifo_d  = data_a[grant_q];
`endif

  // rotating priority: scan upward from the requester after the last owner
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(last_q) + i) % NREQ;
      if (!found && bus.req_valid[idx]) begin
        winner = IDW'(idx);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = winner;
          cnt_d   = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        if (hs) begin
          // the beat cap releases the port even mid-packet
          if (bus.req_last[grant_q] || cnt_q == BCW'(MAXB - 1)) begin
            state_d = IDLE;
            last_d  = grant_q;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + BCW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wclk or negedge wreset_n) begin
    if (!wreset_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IDW'(NREQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule
